mem_stage: RTL and testbench

- Memory-access pipeline stage downstream of the execute stage.
- Consumes the execute stage's registered output (valid flag `exe_mem`, result bus, mem control).
- Issues loads/stores on a valid/ready memory port, zero-extends load data and presents one writeback record per accepted op.
- Drives `mem_blocked` back upstream; execute holds its outputs while `mem_blocked`=1.

---
 rtl/mem_stage_if.sv | 40 ++++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_stage.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the execute-side, memory-port and writeback signals
// of the memory-access stage.
//   master : the mem_stage itself (drives mem_blocked, req_*, wb_*, mem_error)
//   slave  : surrounding pipeline / memory model (drives exe_*, req_ready, resp_*)
interface mem_stage_if;
  logic         exe_mem;
  logic [127:0] result;
  logic [63:0]  store_data;
  logic [1:0]   mem_op;
  logic [1:0]   mem_size;
  logic [3:0]   dest_reg;
  logic         mem_blocked;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [63:0]  req_addr;
  logic [63:0]  req_wdata;
  logic [1:0]   req_size;
  logic         resp_valid;
  logic [63:0]  resp_rdata;
  logic         wb_valid;
  logic         wb_we;
  logic [3:0]   wb_reg;
  logic [63:0]  wb_data;
  logic         mem_error;

  modport master (
    input  exe_mem, result, store_data, mem_op, mem_size, dest_reg,
           req_ready, resp_valid, resp_rdata,
    output mem_blocked, req_valid, req_write, req_addr, req_wdata, req_size,
           wb_valid, wb_we, wb_reg, wb_data, mem_error
  );

  modport slave (
    output exe_mem, result, store_data, mem_op, mem_size, dest_reg,
           req_ready, resp_valid, resp_rdata,
    input  mem_blocked, req_valid, req_write, req_addr, req_wdata, req_size,
           wb_valid, wb_we, wb_reg, wb_data, mem_error
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Captures one execute op while idle,
// issues loads/stores on a valid/ready port, zero-extends load data and emits
// one writeback pulse per accepted op. Loads that see no response within
// TIMEOUT wait cycles are abandoned and set the sticky mem_error flag.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_stage_if.master (execute inputs, memory port, writeback)
//
// state | meaning
// IDLE  | ready to capture an op; NONE ops retire here in one cycle
// REQ   | request presented, waiting for req_ready
// WAIT  | load accepted, waiting for resp_valid or timeout
module mem_stage #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      reset_n,
  mem_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  // Down-counter preset; terminal count (0) is the last wait cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q,     state_d;
  logic        is_store_q,  is_store_d;
  logic [1:0]  size_q,      size_d;
  logic [3:0]  dest_q,      dest_d;
  logic [63:0] addr_q,      addr_d;
  logic [63:0] wdata_q,     wdata_d;
  logic        req_valid_q, req_valid_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic        wb_valid_q,  wb_valid_d;
  logic        wb_we_q,     wb_we_d;
  logic [3:0]  wb_reg_q,    wb_reg_d;
  logic [63:0] wb_data_q,   wb_data_d;
  logic        mem_error_q, mem_error_d;

  // Only the low half of the execute result carries the address/value.
  logic unused_result_hi;
  assign unused_result_hi = ^bus.result[127:64];

  function automatic logic [63:0] zext(input logic [1:0] sz, input logic [63:0] d);
    case (sz)
      2'd0:    return {56'd0, d[7:0]};
      2'd1:    return {48'd0, d[15:0]};
      2'd2:    return {32'd0, d[31:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    size_d      = size_q;
    dest_d      = dest_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_valid_d = req_valid_q;
    cnt_d       = cnt_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we_q;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    mem_error_d = mem_error_q;

    case (state_q)
      IDLE: begin
        if (bus.exe_mem) begin
          addr_d     = bus.result[63:0];
          wdata_d    = bus.store_data;
          size_d     = bus.mem_size;
          dest_d     = bus.dest_reg;
          is_store_d = (bus.mem_op == OP_STORE);
          if (bus.mem_op == OP_LOAD || bus.mem_op == OP_STORE) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b1;
            wb_reg_d   = bus.dest_reg;
            wb_data_d  = bus.result[63:0];
          end
        end
      end
      REQ: begin
        if (bus.req_ready) begin
          req_valid_d = 1'b0;
          if (is_store_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_reg_d   = dest_q;
            wb_data_d  = 64'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = TMO_LAST;
          end
        end
      end
      WAIT: begin
        // A response arriving on the expiry edge takes priority over the timeout.
        if (bus.resp_valid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b1;
          wb_reg_d   = dest_q;
          wb_data_d  = zext(size_q, bus.resp_rdata);
        end else if (cnt_q == 8'd0) begin
          state_d     = IDLE;
          mem_error_d = 1'b1;
          wb_valid_d  = 1'b1;
          wb_we_d     = 1'b0;
          wb_reg_d    = dest_q;
          wb_data_d   = 64'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      size_q      <= 2'd0;
      dest_q      <= 4'd0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      req_valid_q <= 1'b0;
      cnt_q       <= 8'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_reg_q    <= 4'd0;
      wb_data_q   <= 64'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      size_q      <= size_d;
      dest_q      <= dest_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_valid_q <= req_valid_d;
      cnt_q       <= cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign bus.mem_blocked = (state_q != IDLE);
  assign bus.req_valid   = req_valid_q;
  assign bus.req_write   = is_store_q;
  assign bus.req_addr    = addr_q;
  assign bus.req_wdata   = wdata_q;
  assign bus.req_size    = size_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_reg      = wb_reg_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.mem_error   = mem_error_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int TMO = 4;
  localparam logic [63:0] R1 = 64'hFFEE_DDCC_BBAA_9988;
  localparam logic [63:0] R2 = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  rg;
    logic [63:0] data;
    logic        chk_data;
  } wb_exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sz;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [3:0]  dest;
    int          rdly;
    int          pdly;
    logic        exp_we;
    logic [63:0] exp_data;
  } vec_t;

  wb_exp_t sb_q[$];
  wb_exp_t mon_e;
  vec_t    vecs[9];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] sz,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input logic [3:0] dest,
                              input int rdly, input int pdly,
                              input logic exp_we, input logic [63:0] exp_data);
    vec_t v;
    v.op = op; v.sz = sz; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.dest = dest; v.rdly = rdly; v.pdly = pdly; v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  function automatic wb_exp_t exp_rec(input logic we, input logic [3:0] rg,
                                      input logic [63:0] data, input logic chk_data);
    wb_exp_t e;
    e.we = we; e.rg = rg; e.data = data; e.chk_data = chk_data;
    return e;
  endfunction

  task automatic drive_op(input logic [1:0] op, input logic [1:0] sz, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [3:0] dest);
    bus.exe_mem    = 1'b1;
    bus.result     = {64'hCAFE_0000_0000_F00D, addr};
    bus.store_data = wdata;
    bus.mem_op     = op;
    bus.mem_size   = sz;
    bus.dest_reg   = dest;
  endtask

  task automatic drop_op();
    bus.exe_mem    = 1'b0;
    bus.result     = {2{64'h5A5A_5A5A_5A5A_5A5A}};
    bus.store_data = 64'h1111_2222_3333_4444;
    bus.mem_op     = 2'd1;
    bus.mem_size   = 2'd3;
    bus.dest_reg   = 4'hE;
  endtask

  task automatic run_op(input vec_t v);
    drive_op(v.op, v.sz, v.addr, v.wdata, v.dest);
    sb_q.push_back(exp_rec(v.exp_we, v.dest, v.exp_data, 1'b1));
    step();
    drop_op();
    if (v.op == 2'd1 || v.op == 2'd2) begin
      chk("blocked_after_capture", bus.mem_blocked, 1'b1);
      chk("req_valid", bus.req_valid, 1'b1);
      chk("req_write", bus.req_write, (v.op == 2'd2));
      chk("req_addr", bus.req_addr, v.addr);
      chk("req_size", bus.req_size, v.sz);
      if (v.op == 2'd2) chk("req_wdata", bus.req_wdata, v.wdata);
      for (int i = 0; i < v.rdly; i++) begin
        step();
        chk("req_hold_valid", bus.req_valid, 1'b1);
        chk("req_hold_addr", bus.req_addr, v.addr);
      end
      bus.req_ready = 1'b1;
      step();
      bus.req_ready = 1'b0;
      chk("req_drop", bus.req_valid, 1'b0);
      if (v.op == 2'd1) begin
        chk("blocked_in_wait", bus.mem_blocked, 1'b1);
        for (int i = 0; i < v.pdly; i++) step();
        bus.resp_valid = 1'b1;
        bus.resp_rdata = v.rdata;
        step();
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
    chk("blocked_after_op", bus.mem_blocked, 1'b0);
  endtask

  always @(negedge clk) begin
    if (bus.wb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_unexpected: got pulse reg=%0d data=%0h expected no pulse (t=%0t)",
                 bus.wb_reg, bus.wb_data, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_we", bus.wb_we, mon_e.we);
        if (mon_e.we) chk("wb_reg", bus.wb_reg, mon_e.rg);
        if (mon_e.chk_data) chk("wb_data", bus.wb_data, mon_e.data);
      end
    end
  end

  initial begin
    vecs[0] = mk(2'd1, 2'd0, 64'h1000, 64'h0,        R1, 4'd7,  2, 1, 1'b1, 64'h88);
    vecs[1] = mk(2'd1, 2'd1, 64'h1008, 64'h0,        R1, 4'd1,  0, 0, 1'b1, 64'h9988);
    vecs[2] = mk(2'd1, 2'd2, 64'h1010, 64'h0,        R1, 4'd2,  1, 3, 1'b1, 64'hBBAA_9988);
    vecs[3] = mk(2'd1, 2'd3, 64'h1018, 64'h0,        R1, 4'd15, 0, 2, 1'b1, R1);
    vecs[4] = mk(2'd2, 2'd2, 64'h2000, 64'hDEADBEEF, 0,  4'd0,  0, 0, 1'b0, 64'h0);
    vecs[5] = mk(2'd0, 2'd0, 64'hA5A5, 64'h0,        0,  4'd9,  0, 0, 1'b1, 64'hA5A5);
    vecs[6] = mk(2'd3, 2'd1, 64'h77,   64'h0,        0,  4'd2,  0, 0, 1'b1, 64'h77);
    vecs[7] = mk(2'd2, 2'd0, 64'h3000, 64'h12,       0,  4'd4,  3, 0, 1'b0, 64'h0);
    vecs[8] = mk(2'd1, 2'd1, 64'h4444, 64'h0,        R2, 4'd11, 1, 1, 1'b1, 64'hCDEF);

    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 64'h0;
    drop_op();

    #1;
    chk("rst_blocked", bus.mem_blocked, 1'b0);
    chk("rst_req_valid", bus.req_valid, 1'b0);
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_mem_error", bus.mem_error, 1'b0);
    chk("rst_wb_data", bus.wb_data, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Idle with exe_mem low: nothing happens.
    step();
    chk("idle_blocked", bus.mem_blocked, 1'b0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Three back-to-back NONE ops, one record per cycle.
    for (int i = 0; i < 3; i++) begin
      drive_op(2'd0, 2'd0, 64'h1234, 64'h0, 4'd3);
      sb_q.push_back(exp_rec(1'b1, 4'd3, 64'h1234, 1'b1));
      step();
      chk("b2b_blocked", bus.mem_blocked, 1'b0);
    end
    drop_op();
    step();

    // Store with immediate ready; execute presents the next op while blocked.
    drive_op(2'd2, 2'd2, 64'h2000, 64'hDEADBEEF, 4'd0);
    sb_q.push_back(exp_rec(1'b0, 4'd0, 64'h0, 1'b1));
    step();
    chk("st_blocked", bus.mem_blocked, 1'b1);
    chk("st_req_write", bus.req_write, 1'b1);
    chk("st_req_wdata", bus.req_wdata, 64'hDEADBEEF);
    drive_op(2'd0, 2'd0, 64'h55, 64'h0, 4'd5);
    sb_q.push_back(exp_rec(1'b1, 4'd5, 64'h55, 1'b1));
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    chk("st_retired_blocked", bus.mem_blocked, 1'b0);
    step();
    drop_op();
    step();
    step();

    // Dword load whose response lands on the timeout-expiry edge.
    drive_op(2'd1, 2'd2, 64'h4000, 64'h0, 4'd6);
    sb_q.push_back(exp_rec(1'b1, 4'd6, 64'hBBAA_9988, 1'b1));
    step();
    drop_op();
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    repeat (TMO - 1) step();
    bus.resp_valid = 1'b1;
    bus.resp_rdata = R1;
    step();
    bus.resp_valid = 1'b0;
    chk("race_mem_error", bus.mem_error, 1'b0);
    chk("race_blocked", bus.mem_blocked, 1'b0);

    // Load with no response: timeout after TMO wait cycles.
    drive_op(2'd1, 2'd0, 64'h5000, 64'h0, 4'd8);
    sb_q.push_back(exp_rec(1'b0, 4'd8, 64'h0, 1'b0));
    step();
    drop_op();
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    repeat (TMO - 1) step();
    chk("tmo_err_early", bus.mem_error, 1'b0);
    chk("tmo_blocked_early", bus.mem_blocked, 1'b1);
    step();
    chk("tmo_mem_error", bus.mem_error, 1'b1);
    chk("tmo_blocked", bus.mem_blocked, 1'b0);
    drive_op(2'd0, 2'd0, 64'h99, 64'h0, 4'd4);
    sb_q.push_back(exp_rec(1'b1, 4'd4, 64'h99, 1'b1));
    step();
    drop_op();
    step();
    chk("tmo_sticky", bus.mem_error, 1'b1);

    // Reset while in WAIT; a late response must not produce a writeback.
    drive_op(2'd1, 2'd3, 64'h6000, 64'h0, 4'd10);
    step();
    drop_op();
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_blocked", bus.mem_blocked, 1'b0);
    chk("arst_req_valid", bus.req_valid, 1'b0);
    chk("arst_req_addr", bus.req_addr, 64'h0);
    chk("arst_wb_valid", bus.wb_valid, 1'b0);
    chk("arst_wb_reg", bus.wb_reg, 4'd0);
    chk("arst_wb_data", bus.wb_data, 64'h0);
    chk("arst_mem_error", bus.mem_error, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    bus.resp_valid = 1'b1;
    bus.resp_rdata = R1;
    step();
    bus.resp_valid = 1'b0;
    chk("late_resp_wb", bus.wb_valid, 1'b0);
    chk("late_resp_blocked", bus.mem_blocked, 1'b0);
    step();
    step();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
